// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and defaults for the shift register command sequencer.
// Holds the FSM state type, default sizing, and the shift-count clamp.
package shift_reg_ctrl_pkg;

  localparam int DEF_W          = 8;
  localparam int DEF_GUARD_CYC  = 2;
  localparam int DEF_MAX_SHIFTS = 8;
  localparam int DEF_CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GUARD,
    SHIFT,
    SETTLE,
    RESULT
  } state_t;

  function automatic int clamp_shifts(
    input int n,
    input int max_n
  );
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/shift_reg_ctrl.sv
// Sequences one load then N shifts on an external shift register and
// returns its data_out over a valid/ready result handshake.
// Ports: clk, rst (async, active-low); cmd_valid/cmd_ready/cmd_data/
// cmd_shifts command side; load_en/shift_en/data_in/data_out register
// side; res_valid/res_ready/res_data result side; busy status.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int GUARD_CYC  = DEF_GUARD_CYC,
  parameter int MAX_SHIFTS = DEF_MAX_SHIFTS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_data,
  input  logic [CNT_W-1:0] cmd_shifts,
  output logic             load_en,
  output logic             shift_en,
  output logic [W-1:0]     data_in,
  input  logic [W-1:0]     data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             busy
);

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_shift_cnt;
  logic [GW-1:0]    r_guard_cnt;
  logic [CNT_W-1:0] w_clamped;

  assign w_clamped =
    CNT_W'(clamp_shifts(int'(cmd_shifts), MAX_SHIFTS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shift_cnt <= '0;
      r_guard_cnt <= '0;
      cmd_ready   <= 1'b0;
      load_en     <= 1'b0;
      shift_en    <= 1'b0;
      data_in     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // cmd_ready stays low for one cycle after reset release
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            load_en     <= 1'b1;
            data_in     <= cmd_data;
            r_shift_cnt <= w_clamped;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          load_en     <= 1'b0;
          r_guard_cnt <= GW'(GUARD_CYC - 1);
          r_state     <= GUARD;
        end
        GUARD: begin
          if (r_guard_cnt == '0) begin
            if (r_shift_cnt != '0) begin
              shift_en <= 1'b1;
              r_state  <= SHIFT;
            end else begin
              r_state  <= SETTLE;
            end
          end else begin
            r_guard_cnt <= r_guard_cnt - 1'b1;
          end
        end
        SHIFT: begin
          r_shift_cnt <= r_shift_cnt - 1'b1;
          if (r_shift_cnt == CNT_W'(1)) begin
            shift_en <= 1'b0;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          res_data  <= data_out;
          res_valid <= 1'b1;
          r_state   <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
